movwide_const_encoder: RTL and testbench

- Sequential encoder that turns a 64-bit constant and a destination register into the shortest LEGv8 MOVZ/MOVK instruction sequence that rebuilds the constant.
- It is the inverse of the datapath's wide-immediate extension: Ctrl 100..111 places Imm[20:5] at halfword 0..3.
- Used by the test-program generator and the instruction-injection path ahead of instruction memory.
- Emits one 32-bit instruction word per output handshake.

---
 rtl/movwide_const_encoder_if.sv | 24 ++
 rtl/movwide_const_encoder.sv | 148 ++++++++++++++
 tb/tb_movwide_const_encoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/movwide_const_encoder_if.sv
// Request/response bundle for the MOVZ/MOVK sequence encoder.
// The encoder side uses the slave modport; the requester/consumer side uses master.
interface movwide_const_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] imm;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  ext_ctrl;
  logic        out_last;
  logic        busy;

  modport master (
    output in_valid, imm, rd, out_ready,
    input  in_ready, out_valid, instr, ext_ctrl, out_last, busy
  );

  modport slave (
    input  in_valid, imm, rd, out_ready,
    output in_ready, out_valid, instr, ext_ctrl, out_last, busy
  );
endinterface

// File: rtl/movwide_const_encoder.sv
// Turns a 64-bit constant plus destination register into the shortest LEGv8
// MOVZ/MOVK sequence, one registered 32-bit word per output handshake.
module movwide_const_encoder #(
  parameter int unsigned SKIP_ZERO = 1,
  parameter logic [8:0]  OPC_MOVZ  = 9'b110100101,
  parameter logic [8:0]  OPC_MOVK  = 9'b111100101
) (
  input logic                    CLK,
  input logic                    Reset_L,
  movwide_const_encoder_if.slave bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StEmit = 1'b1;

  logic        state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [63:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        first_q, first_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  ext_ctrl_q, ext_ctrl_d;
  logic        out_last_q, out_last_d;

  logic [3:0]  mask;
  logic        load_word;
  logic        clear_word;
  logic [1:0]  hw_n;
  logic [15:0] imm16_n;
  logic        last_n;

  // Halfwords that need a word; an all-zero constant still needs MOVZ hw0 #0.
  always_comb begin
    mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      mask[k] = (SKIP_ZERO != 0) ? (bus.imm[16*k +: 16] != 16'd0) : 1'b1;
    end
    if (mask == 4'b0000) mask = 4'b0001;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    first_d     = first_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    load_word   = 1'b0;
    clear_word  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          imm_d       = bus.imm;
          rd_d        = bus.rd;
          pend_d      = mask;
          first_d     = 1'b1;
          state_d     = StEmit;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          load_word   = 1'b1;
        end
      end
      default: begin
        if (out_valid_q && bus.out_ready) begin
          pend_d  = pend_q & (pend_q - 4'd1);
          first_d = 1'b0;
          if (out_last_q) begin
            state_d     = StIdle;
            pend_d      = 4'b0000;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            clear_word  = 1'b1;
          end else begin
            load_word = 1'b1;
          end
        end
      end
    endcase
  end

  // Next word is built from next-state values so every output stays a flop.
  always_comb begin
    hw_n = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend_d[k]) hw_n = 2'(k);
    end
    imm16_n = 16'(imm_d >> {hw_n, 4'b0000});
    last_n  = ((pend_d & (pend_d - 4'd1)) == 4'd0);
  end

  always_comb begin
    instr_d    = instr_q;
    ext_ctrl_d = ext_ctrl_q;
    out_last_d = out_last_q;
    if (load_word) begin
      instr_d    = {(first_d ? OPC_MOVZ : OPC_MOVK), hw_n, imm16_n, rd_d};
      ext_ctrl_d = {1'b1, hw_n};
      out_last_d = last_n;
    end else if (clear_word) begin
      instr_d    = 32'd0;
      ext_ctrl_d = 3'd0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= StIdle;
      pend_q      <= 4'b0000;
      imm_q       <= 64'd0;
      rd_q        <= 5'd0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      instr_q     <= 32'd0;
      ext_ctrl_q  <= 3'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      instr_q     <= instr_d;
      ext_ctrl_q  <= ext_ctrl_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.instr     = instr_q;
  assign bus.ext_ctrl  = ext_ctrl_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_movwide_const_encoder.sv
// Bench for the MOVZ/MOVK encoder: one instance with zero-skipping, one without,
// checked against a halfword-by-halfword reference model.
module tb_movwide_const_encoder;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        in_valid;
  logic        sel;
  logic        out_ready;
  logic [63:0] imm;
  logic [4:0]  rd;

  always #5 CLK = ~CLK;

  movwide_const_encoder_if bus0 ();
  movwide_const_encoder_if bus1 ();

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus0.imm       = imm;
  assign bus0.rd        = rd;
  assign bus0.out_ready = out_ready & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus1.imm       = imm;
  assign bus1.rd        = rd;
  assign bus1.out_ready = out_ready & sel;

  movwide_const_encoder #(.SKIP_ZERO(1)) u_dut_skip (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus0)
  );

  movwide_const_encoder #(.SKIP_ZERO(0)) u_dut_all (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus1)
  );

  logic        o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [31:0] o_instr;
  logic [2:0]  o_ext_ctrl;

  assign o_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
  assign o_out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign o_out_last  = sel ? bus1.out_last  : bus0.out_last;
  assign o_busy      = sel ? bus1.busy      : bus0.busy;
  assign o_instr     = sel ? bus1.instr     : bus0.instr;
  assign o_ext_ctrl  = sel ? bus1.ext_ctrl  : bus0.ext_ctrl;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w[$];
  logic [1:0]  exp_h[$];
  logic [31:0] first_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one word per needed halfword, ascending, first is MOVZ.
  task automatic model(input logic [63:0] v, input logic [4:0] r, input bit skip);
    logic [15:0] h16;
    logic [8:0]  opc;
    exp_w.delete();
    exp_h.delete();
    for (int h = 0; h < 4; h++) begin
      h16 = v[16*h +: 16];
      if (!skip || h16 != 16'd0) begin
        opc = (exp_w.size() == 0) ? 9'h1A5 : 9'h1E5;
        exp_w.push_back({opc, 2'(h), h16, r});
        exp_h.push_back(2'(h));
      end
    end
    if (exp_w.size() == 0) begin
      exp_w.push_back({9'h1A5, 2'd0, 16'd0, r});
      exp_h.push_back(2'd0);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_in_ready && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_wait", o_in_ready, 1);
  endtask

  task automatic send(input logic [63:0] v, input logic [4:0] r, input bit s, input bit stall);
    sel = s;
    model(v, r, !s);
    wait_ready();
    in_valid  = 1'b1;
    imm       = v;
    rd        = r;
    out_ready = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    chk("busy_emit", o_busy, 1);
    chk("in_ready_emit", o_in_ready, 0);
    foreach (exp_w[i]) begin
      do begin
        chk("out_valid", o_out_valid, 1);
        chk("instr", o_instr, exp_w[i]);
        chk("ext_ctrl", o_ext_ctrl, {1'b1, exp_h[i]});
        chk("out_last", o_out_last, (i == exp_w.size() - 1));
        if (i == 0) first_word = o_instr;
        out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge CLK);
      end while (!out_ready);
    end
    out_ready = 1'b0;
    chk("idle_out_valid", o_out_valid, 0);
    chk("idle_in_ready", o_in_ready, 1);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    Reset_L    = 1'b0;
    in_valid   = 1'b0;
    sel        = 1'b0;
    out_ready  = 1'b0;
    imm        = 64'd0;
    rd         = 5'd0;
    first_word = 32'd0;
    #1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_ext_ctrl", o_ext_ctrl, 0);
    chk("rst_out_last", o_out_last, 0);
    chk("rst_all_out_valid", bus1.out_valid, 0);
    repeat (2) @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    chk("rst_release_in_ready", o_in_ready, 1);

    send(64'h0000_0000_0000_1234, 5'd9, 1'b0, 1'b0);
    chk("case1_word", first_word, 32'hD282_4689);
    send(64'h0001_0000_0000_0000, 5'd0, 1'b0, 1'b0);
    chk("case2_word", first_word, 32'hD2E0_0020);
    send(64'hFFFF_0000_ABCD_0000, 5'd1, 1'b0, 1'b0);
    chk("case3_word", first_word, 32'hD2B5_79A1);
    send(64'd0, 5'd5, 1'b0, 1'b0);
    chk("case4_word", first_word, 32'hD280_0005);
    send(64'h0000_0000_0000_0001, 5'd2, 1'b1, 1'b0);
    chk("case5_word", first_word, 32'hD280_0022);

    // Back-pressure on word 1, then reset before word 2 is taken.
    sel = 1'b0;
    model(64'hFFFF_0000_ABCD_0000, 5'd1, 1'b1);
    wait_ready();
    in_valid = 1'b1;
    imm      = 64'hFFFF_0000_ABCD_0000;
    rd       = 5'd1;
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (5) begin
      chk("bp_out_valid", o_out_valid, 1);
      chk("bp_instr", o_instr, exp_w[0]);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk("bp_word2", o_instr, exp_w[1]);
    #2 Reset_L = 1'b0;
    #1;
    chk("abort_out_valid", o_out_valid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_instr", o_instr, 0);
    chk("abort_out_last", o_out_last, 0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    chk("abort_in_ready", o_in_ready, 1);
    chk("abort_idle", o_out_valid, 0);
    send(64'h0000_0000_0000_00AB, 5'd3, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      for (int h = 0; h < 4; h++) begin
        if ($urandom_range(0, 1) == 0) v[16*h +: 16] = 16'd0;
      end
      send(v, 5'($urandom_range(0, 31)), bit'(t % 3 == 2), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
